// File: rtl/wide_add_seq.sv
// ---------------------------------------------------------------------------
// wide_add_seq -- multi-cycle wide adder built around one 18-bit prefix adder.
//
// A request (in_a, in_b, in_cin) is captured in IDLE. The block then spends
// NSEG cycles in RUN, adding one 18-bit segment per cycle and rippling the
// carry through a carry register. The finished (W+1)-bit result is presented
// in DONE and held until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept a request (registered, state only)
//   in_a/in_b  W-bit operands, W = 18*NSEG
//   in_cin     carry-in to segment 0
//   out_valid  result valid (registered, state only)
//   out_ready  consumer accepts result
//   out_sum    registered W-bit sum
//   out_cout   registered carry-out of the top segment
// ---------------------------------------------------------------------------

// 18-bit Kogge-Stone prefix adder used for one segment per cycle.
//   a, b  18-bit addends
//   cin   carry-in
//   sum   18-bit sum
//   cout  carry-out
module adder (
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic        cin,
    output logic [17:0] sum,
    output logic        cout
);

    logic [17:0] gen_s;
    logic [17:0] prop_s;
    logic [17:0] grp_g_s;
    logic [17:0] grp_p_s;
    logic [17:0] nxt_g_s;
    logic [17:0] nxt_p_s;
    logic [17:0] carry_s;

    // Prefix tree: grp_g_s[i]/grp_p_s[i] end up covering bits i..0.
    always_comb begin
        gen_s   = a & b;
        prop_s  = a ^ b;
        grp_g_s = gen_s;
        grp_p_s = prop_s;
        nxt_g_s = gen_s;
        nxt_p_s = prop_s;
        for (int d = 1; d < 18; d = d * 2) begin
            nxt_g_s = grp_g_s;
            nxt_p_s = grp_p_s;
            for (int i = d; i < 18; i++) begin
                nxt_g_s[i] = grp_g_s[i] | (grp_p_s[i] & grp_g_s[i-d]);
                nxt_p_s[i] = grp_p_s[i] & grp_p_s[i-d];
            end
            grp_g_s = nxt_g_s;
            grp_p_s = nxt_p_s;
        end
    end

    // Per-bit carries folded with the external carry-in, then the sum.
    always_comb begin
        carry_s    = 18'd0;
        carry_s[0] = cin;
        for (int i = 1; i < 18; i++) begin
            carry_s[i] = grp_g_s[i-1] | (grp_p_s[i-1] & cin);
        end
        sum  = prop_s ^ carry_s;
        cout = grp_g_s[17] | (grp_p_s[17] & cin);
    end

endmodule

module wide_add_seq #(
    parameter int NSEG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [18*NSEG-1:0] in_a,
    input  logic [18*NSEG-1:0] in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [18*NSEG-1:0] out_sum,
    output logic               out_cout
);

    localparam int W  = 18 * NSEG;
    localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry_r;
    logic [SW-1:0] seg_r;
    logic [W-1:0]  sum_r;
    logic          cout_r;
    logic          ready_r;
    logic          valid_r;
    logic [17:0]   slice_a_s;
    logic [17:0]   slice_b_s;
    logic [17:0]   slice_sum_s;
    logic          slice_cout_s;

    adder u_adder (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Select the operand segment addressed by the segment counter.
    always_comb begin
        slice_a_s = 18'd0;
        slice_b_s = 18'd0;
        for (int k = 0; k < NSEG; k++) begin
            slice_a_s = (seg_r == SW'(k)) ? a_r[18*k +: 18] : slice_a_s;
            slice_b_s = (seg_r == SW'(k)) ? b_r[18*k +: 18] : slice_b_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (seg_r == SEG_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; handshake flags are registered decodes of the next state
    // so they never combinationally depend on in_valid or out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == IDLE);
            valid_r <= (state_nx_s == DONE);
        end
    end

    // Operand capture, segment stepping and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            seg_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        seg_r   <= '0;
                    end
                end
                RUN: begin
                    carry_r <= slice_cout_s;
                    for (int k = 0; k < NSEG; k++) begin
                        if (seg_r == SW'(k)) begin
                            sum_r[18*k +: 18] <= slice_sum_s;
                        end
                    end
                    // Counter parks at zero after the top segment instead of
                    // running past NSEG-1.
                    if (seg_r == SEG_LAST) begin
                        cout_r <= slice_cout_s;
                        seg_r  <= '0;
                    end else begin
                        seg_r  <= seg_r + SW'(1);
                    end
                end
                DONE: begin
                    seg_r <= '0;
                end
                default: begin
                    seg_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_sum   = sum_r;
    assign out_cout  = cout_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// ---------------------------------------------------------------------------
// Testbench for wide_add_seq. Three instances (NSEG = 1, 4, 8) share one
// stimulus stream; a transaction-level model per instance (one result in
// flight, ready after NSEG cycles, value = a + b + cin) checks every cycle.
// Directed steps on the NSEG=4 instance cover carry ripple, all-ones,
// backpressure, operand changes in flight and reset mid-RUN.
// ---------------------------------------------------------------------------
module tb_wide_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_cin;
    logic         out_ready;
    logic [143:0] in_a;
    logic [143:0] in_b;

    logic         rdy1, rdy4, rdy8;
    logic         ov1, ov4, ov8;
    logic         co1, co4, co8;
    logic [17:0]  s1;
    logic [71:0]  s4;
    logic [143:0] s8;

    int checks = 0;
    int errors = 0;

    wide_add_seq #(.NSEG(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a[17:0]), .in_b(in_b[17:0]), .in_cin(in_cin),
        .out_valid(ov1), .out_ready(out_ready), .out_sum(s1), .out_cout(co1)
    );
    wide_add_seq #(.NSEG(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .in_a(in_a[71:0]), .in_b(in_b[71:0]), .in_cin(in_cin),
        .out_valid(ov4), .out_ready(out_ready), .out_sum(s4), .out_cout(co4)
    );
    wide_add_seq #(.NSEG(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(ov8), .out_ready(out_ready), .out_sum(s8), .out_cout(co8)
    );

    // Reference model state, one slot per instance.
    int           nseg [3] = '{1, 4, 8};
    bit           exp_v [3];
    logic [144:0] exp_val [3];
    int           age [3];
    bit           model_on = 1'b0;

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy1 : (d == 1) ? rdy4 : rdy8;
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 0) ? ov1 : (d == 1) ? ov4 : ov8;
    endfunction

    function automatic logic [144:0] get_res(input int d);
        if (d == 0) return {126'd0, co1, s1};
        if (d == 1) return {72'd0, co4, s4};
        return {co8, s8};
    endfunction

    function automatic logic [144:0] ref_sum(input int d, input logic [143:0] a,
                                             input logic [143:0] b, input logic c);
        logic [144:0] m;
        m = (145'd1 << (18 * nseg[d])) - 145'd1;
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {144'd0, c};
    endfunction

    function automatic logic [143:0] rnd144();
        logic [159:0] t;
        int sel;
        t   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        sel = $urandom_range(0, 7);
        if (sel == 0) return {144{1'b1}};
        if (sel == 1) return 144'd0;
        return t[143:0];
    endfunction

    task automatic chk(input string tag, input logic [144:0] o, input logic [144:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model by the handshakes that happen at the coming edge.
    task automatic step(input logic r, input logic v, input logic [143:0] a,
                        input logic [143:0] b, input logic c, input logic ordy);
        rst = r; in_valid = v; in_a = a; in_b = b; in_cin = c; out_ready = ordy;
        for (int d = 0; d < 3; d++) begin
            if (model_on) begin
                chk($sformatf("in_ready[nseg=%0d]", nseg[d]),
                    145'(get_rdy(d)), 145'(!exp_v[d]));
                chk($sformatf("out_valid[nseg=%0d]", nseg[d]),
                    145'(get_ov(d)), 145'(exp_v[d] && age[d] >= nseg[d]));
                if (exp_v[d] && age[d] >= nseg[d] && ordy && !r) begin
                    chk($sformatf("result[nseg=%0d]", nseg[d]), get_res(d), exp_val[d]);
                end
            end
            if (r) begin
                exp_v[d] = 1'b0;
                age[d]   = 0;
            end else if (v && !exp_v[d]) begin
                exp_v[d]   = 1'b1;
                age[d]     = 0;
                exp_val[d] = ref_sum(d, a, b, c);
            end else if (exp_v[d] && age[d] >= nseg[d] && ordy) begin
                exp_v[d] = 1'b0;
            end else if (exp_v[d] && age[d] < 100) begin
                age[d]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic v, input logic ordy);
        step(1'b0, v, rnd144(), rnd144(), 1'($urandom_range(0, 1)), ordy);
    endtask

    task automatic wait_ov4();
        int n = 0;
        while (ov4 !== 1'b1 && n < 20) begin
            idle(1'b0, 1'b0);
            n++;
        end
        chk("wait_out_valid4", 145'(ov4), 145'd1);
    endtask

    logic [143:0] ones;
    logic [71:0]  held_sum;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        ones = {144{1'b1}};
        for (int d = 0; d < 3; d++) begin
            exp_v[d] = 1'b0; exp_val[d] = '0; age[d] = 0;
        end
        @(negedge clk);

        // Reset with in_valid asserted: the request must not be taken.
        step(1'b1, 1'b1, 144'd5, 144'd6, 1'b1, 1'b0);
        model_on = 1'b1;
        step(1'b1, 1'b1, 144'd5, 144'd6, 1'b1, 1'b0);
        chk("reset_in_ready", 145'(rdy4), 145'd1);
        chk("reset_out_valid", 145'(ov4), 145'd0);
        chk("reset_sum4", {72'd0, co4, s4}, 145'd0);
        chk("reset_sum8", {co8, s8}, 145'd0);

        // Carry ripples through all four segments; out_valid exactly 4 edges on.
        step(1'b0, 1'b1, 144'h1_FFFF_FFFF_FFFF_FFFF, 144'd1, 1'b0, 1'b0);
        idle(1'b0, 1'b0); idle(1'b0, 1'b0); idle(1'b0, 1'b0);
        chk("latency_not_yet", 145'(ov4), 145'd0);
        idle(1'b0, 1'b0);
        chk("latency_valid", 145'(ov4), 145'd1);
        chk("ripple_sum", {72'd0, co4, s4}, {72'd0, 1'b0, 72'h02_0000_0000_0000_0000});
        idle(1'b0, 1'b1);

        // All ones plus carry-in.
        step(1'b0, 1'b1, ones, ones, 1'b1, 1'b0);
        wait_ov4();
        chk("ones_sum", {72'd0, co4, s4}, {72'd0, 1'b1, {72{1'b1}}});

        // Backpressure: result held, ready low, new requests ignored.
        held_sum = s4;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1, 1'b0);
            chk("bp_valid", 145'(ov4), 145'd1);
            chk("bp_sum", {73'd0, s4}, {73'd0, held_sum});
            chk("bp_ready", 145'(rdy4), 145'd0);
        end
        idle(1'b1, 1'b1);
        chk("bp_release_ready", 145'(rdy4), 145'd1);
        chk("bp_release_valid", 145'(ov4), 145'd0);

        // Operands changing while in flight must not matter.
        step(1'b0, 1'b1, 144'd5, 144'd7, 1'b0, 1'b0);
        wait_ov4();
        chk("inflight_sum", {72'd0, co4, s4}, 145'd12);
        idle(1'b0, 1'b1);

        // Reset mid-RUN at segment 2 discards the result.
        step(1'b0, 1'b1, 144'd9, 144'd9, 1'b0, 1'b0);
        idle(1'b0, 1'b0); idle(1'b0, 1'b0);
        step(1'b1, 1'b0, 144'd0, 144'd0, 1'b0, 1'b1);
        chk("midrun_rst_ready", 145'(rdy4), 145'd1);
        chk("midrun_rst_valid", 145'(ov4), 145'd0);
        chk("midrun_rst_sum", {72'd0, co4, s4}, 145'd0);
        step(1'b0, 1'b1, 144'd3, 144'd4, 1'b1, 1'b0);
        wait_ov4();
        chk("post_rst_sum", {72'd0, co4, s4}, 145'd8);
        idle(1'b0, 1'b1);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), rnd144(), rnd144(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left pending.
        for (int i = 0; i < 30; i++) begin
            idle(1'b0, 1'b1);
        end
        chk("drain_valid1", 145'(ov1), 145'd0);
        chk("drain_valid4", 145'(ov4), 145'd0);
        chk("drain_valid8", 145'(ov8), 145'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
